// File: rtl/pmem_burst_adapter.sv
// Splits 256-bit cache line transfers into four 64-bit memory beats and reassembles read beats.
// Latency: 1 request cycle + 4 beat cycles + 1 DONE cycle; memory stalls (resp_i=0) hold the beat.
module pmem_burst_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [255:0] buffer;
  logic [31:0]  addr;
  logic [7:0]   beat_lsb;

  assign beat_lsb = {cnt, 6'd0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      buffer <= 256'd0;
      addr   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // write wins when both requests arrive together
          if (write_i) begin
            addr   <= address_i;
            buffer <= line_i;
            cnt    <= 2'd0;
            state  <= WRITE;
          end else if (read_i) begin
            addr  <= address_i;
            cnt   <= 2'd0;
            state <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            buffer[beat_lsb +: 64] <= burst_i;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = (read_o || write_o) ? {addr[31:5], 5'd0} : 32'd0;
  assign burst_o   = write_o ? buffer[beat_lsb +: 64] : 64'd0;
  assign line_o    = buffer;

endmodule

// File: tb/tb_pmem_burst_adapter.sv
module tb_pmem_burst_adapter;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks;
  int failures;

  pmem_burst_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [63:0]  rb [4];
  logic [63:0]  wb [4];
  logic [255:0] wline;
  logic [255:0] exp_line;
  int           pat [7];
  int           k;
  int           pulses;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    tick(); tick();
    check("rst_resp_o",    256'(resp_o),    256'd0);
    check("rst_read_o",    256'(read_o),    256'd0);
    check("rst_write_o",   256'(write_o),   256'd0);
    check("rst_address_o", 256'(address_o), 256'd0);
    check("rst_burst_o",   256'(burst_o),   256'd0);
    check("rst_line_o",    line_o,          256'd0);
    rst = 1'b0;
    tick();

    // Read, no stalls
    rb[0] = 64'h1111_1111_1111_1111; rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333; rb[3] = 64'h4444_4444_4444_4444;
    address_i = 32'h0000_1234; read_i = 1'b1;
    tick();
    read_i = 1'b0;
    check("rd_read_o",    256'(read_o),    256'd1);
    check("rd_write_o",   256'(write_o),   256'd0);
    check("rd_address_o", 256'(address_o), 256'h0000_1220);
    for (int i = 0; i < 4; i++) begin
      check("rd_no_early_resp", 256'(resp_o), 256'd0);
      burst_i = rb[i]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    check("rd_done_resp_o", 256'(resp_o), 256'd1);
    check("rd_done_read_o", 256'(read_o), 256'd0);
    check("rd_done_addr_o", 256'(address_o), 256'd0);
    check("rd_line_o",      line_o, exp_line);
    tick();
    check("rd_idle_resp_o", 256'(resp_o), 256'd0);
    check("rd_line_hold",   line_o, exp_line);

    // Write with stalls: ack pattern 1,0,1,0,0,1,1
    wb[0] = 64'hDDDD_DDDD_DDDD_DDDD; wb[1] = 64'hCCCC_CCCC_CCCC_CCCC;
    wb[2] = 64'hBBBB_BBBB_BBBB_BBBB; wb[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    wline = {wb[3], wb[2], wb[1], wb[0]};
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 0; pat[5] = 1; pat[6] = 1;
    line_i = wline; address_i = 32'h0000_0F3F; write_i = 1'b1;
    tick();
    write_i = 1'b0; line_i = '0;
    check("wr_write_o",   256'(write_o),   256'd1);
    check("wr_read_o",    256'(read_o),    256'd0);
    check("wr_address_o", 256'(address_o), 256'h0000_0F20);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      check("wr_write_o_held", 256'(write_o), 256'd1);
      check("wr_burst_o", 256'(burst_o), 256'(wb[k]));
      resp_i = (pat[i] == 1);
      tick();
      if (pat[i] == 1) k++;
    end
    resp_i = 1'b0;
    check("wr_done_write_o", 256'(write_o), 256'd0);
    check("wr_done_resp_o",  256'(resp_o),  256'd1);
    check("wr_done_burst_o", 256'(burst_o), 256'd0);
    tick();
    check("wr_idle_resp_o", 256'(resp_o), 256'd0);

    // Simultaneous read and write request: write wins
    line_i = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    address_i = 32'h0000_2000; read_i = 1'b1; write_i = 1'b1;
    tick();
    read_i = 1'b0; write_i = 1'b0;
    check("both_write_o", 256'(write_o), 256'd1);
    check("both_burst0",  256'(burst_o), 256'h0101_0101_0101_0101);
    for (int i = 0; i < 4; i++) begin
      check("both_read_o_low", 256'(read_o), 256'd0);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    check("both_resp_o", 256'(resp_o), 256'd1);
    check("both_read_o_done", 256'(read_o), 256'd0);
    tick();

    // Reset after two read beats
    address_i = 32'h0000_0080; read_i = 1'b1;
    tick();
    read_i = 1'b0;
    burst_i = 64'hEEEE_EEEE_EEEE_EEEE; resp_i = 1'b1;
    tick(); tick();
    rst = 1'b1; read_i = 1'b1; write_i = 1'b1;
    tick();
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    check("mid_rst_read_o", 256'(read_o),    256'd0);
    check("mid_rst_resp_o", 256'(resp_o),    256'd0);
    check("mid_rst_line_o", line_o,          256'd0);
    check("mid_rst_addr_o", 256'(address_o), 256'd0);
    tick();
    check("mid_rst_stays_idle", 256'(read_o), 256'd0);

    // Fresh read after reset, with one stall after beat 1
    rb[0] = 64'h5555_5555_5555_5555; rb[1] = 64'h6666_6666_6666_6666;
    rb[2] = 64'h7777_7777_7777_7777; rb[3] = 64'h8888_8888_8888_8888;
    address_i = 32'h0000_ABCD; read_i = 1'b1;
    tick();
    read_i = 1'b0;
    check("rd2_address_o", 256'(address_o), 256'h0000_ABC0);
    burst_i = rb[0]; resp_i = 1'b1; tick();
    burst_i = 64'hDEAD_BEEF_DEAD_BEEF; resp_i = 1'b0; tick();
    check("rd2_stall_read_o", 256'(read_o), 256'd1);
    for (int i = 1; i < 4; i++) begin
      burst_i = rb[i]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    check("rd2_resp_o", 256'(resp_o), 256'd1);
    check("rd2_line_o", line_o, {rb[3], rb[2], rb[1], rb[0]});
    tick();

    // Spurious resp_i in IDLE
    resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_resp_i_read_o",  256'(read_o),  256'd0);
      check("idle_resp_i_write_o", 256'(write_o), 256'd0);
      check("idle_resp_i_resp_o",  256'(resp_o),  256'd0);
    end
    check("idle_resp_i_line_o", line_o, {rb[3], rb[2], rb[1], rb[0]});

    // read_i held high with continuous acks: one pulse per 6-cycle line
    burst_i = 64'h9999_9999_9999_9999; address_i = 32'h0000_0040; read_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (resp_o) pulses++;
    end
    check("held_req_pulses", 256'(pulses), 256'd2);
    read_i = 1'b0;
    tick();
    check("held_req_tail_resp_o", 256'(resp_o), 256'd0);
    resp_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("held_req_quiesce", 256'(read_o), 256'd0);

    // Back-to-back: read, then write requested during DONE
    address_i = 32'h0000_3000; read_i = 1'b1;
    tick();
    read_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      burst_i = 64'(i + 1); resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    check("b2b_rd_resp_o", 256'(resp_o), 256'd1);
    line_i = {64'hF4, 64'hF3, 64'hF2, 64'hF1}; address_i = 32'h0000_4010; write_i = 1'b1;
    tick();
    check("b2b_done_ignores_write", 256'(write_o), 256'd0);
    tick();
    write_i = 1'b0;
    check("b2b_wr_write_o", 256'(write_o),   256'd1);
    check("b2b_wr_addr_o",  256'(address_o), 256'h0000_4000);
    check("b2b_wr_burst0",  256'(burst_o),   256'h0F1);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    check("b2b_wr_resp_o", 256'(resp_o), 256'd1);
    tick();
    check("b2b_final_idle", 256'(resp_o), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_burst_adapter.md
PMEM_BURST_ADAPTER -- requirements
Module: pmem_burst_adapter

Interface
Parameters: none. Widths are fixed: 256-bit line, 64-bit beat, 4 beats per line.
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port line_i, input, 256 bits: write line from the cache (pmem_wdata side).
REQ-004 SHALL have port line_o, output, 256 bits: assembled read line to the cache (pmem_rdata side).
REQ-005 SHALL have port address_i, input, 32 bits: line address from the cache.
REQ-006 SHALL have port read_i, input, 1 bit: line read request from the cache.
REQ-007 SHALL have port write_i, input, 1 bit: line write request from the cache.
REQ-008 SHALL have port resp_o, output, 1 bit: line transfer complete, to the cache.
REQ-009 SHALL have port burst_i, input, 64 bits: read beat data from memory.
REQ-010 SHALL have port burst_o, output, 64 bits: write beat data to memory.
REQ-011 SHALL have port address_o, output, 32 bits: burst address to memory.
REQ-012 SHALL have port read_o, output, 1 bit: burst read request to memory.
REQ-013 SHALL have port write_o, output, 1 bit: burst write request to memory.
REQ-014 SHALL have port resp_i, input, 1 bit: per-beat acknowledge from memory.

Function
REQ-015 SHALL implement a 4-state FSM: IDLE, READ, WRITE, DONE. It SHALL also have a 2-bit beat counter, a 256-bit line buffer and a 32-bit address register.
REQ-016 In IDLE with write_i=1 at a clock edge: latch address_i and line_i, clear the counter, and go to WRITE. write_i has priority when read_i and write_i are both 1.
REQ-017 In IDLE with only read_i=1: latch address_i, clear the counter, and go to READ.
REQ-018 In IDLE with neither request: hold state.
REQ-019 address_o SHALL equal {latched address[31:5], 5'b0} in READ and WRITE, and 0 otherwise.
REQ-020 read_o SHALL be 1 exactly while in READ. write_o SHALL be 1 exactly while in WRITE. Both are driven from registered state, with no combinational path from resp_i.
REQ-021 In READ, each cycle with resp_i=1: store burst_i into buffer bits [64k+63:64k], where k is the counter, then increment the counter. Cycles with resp_i=0 are stall cycles: no change.
REQ-022 In WRITE: burst_o SHALL equal buffer bits [64k+63:64k] for the current k. Each resp_i=1 cycle increments k. When k is not valid or the FSM is not in WRITE, burst_o=0.
REQ-023 On resp_i=1 with k=3 in READ or WRITE: go to DONE on the next edge, so read_o/write_o drop the cycle after the final beat. The counter wraps to 0.
REQ-024 In DONE, resp_o=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-025 line_o SHALL continuously drive the line buffer. After a read, line_o is valid in the DONE cycle and holds until the next transaction is latched.
REQ-026 Latency, zero-stall memory: request edge -> 4 beat cycles -> resp_o in cycle 6 counting the request cycle as 1. Each stall cycle adds 1.
REQ-027 read_i/write_i SHALL be ignored outside IDLE. A request still asserted in the cycle after DONE starts a new transaction.
REQ-028 resp_i SHALL be ignored in IDLE and DONE.

Reset
REQ-029 When rst=1 at an edge, in any state including mid-burst: state=IDLE, counter=0, buffer=0, address register=0.
REQ-030 Outputs during and after reset: resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0.
REQ-031 rst SHALL take priority over every request and over resp_i in the same cycle.

Verification
REQ-032 Read, no stalls: address_i=0x0000_1234, read_i=1; burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i=1 on 4 consecutive cycles -> address_o=0x0000_1220; then resp_o pulses once with line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
REQ-033 Write with stalls: line_i=0xAAAA..._DDDD (4 distinct beats), write_i=1, resp_i pattern 1,0,1,0,0,1,1 -> burst_o presents the low beat first and advances only on resp_i=1; write_o drops after the 4th ack; resp_o pulses once.
REQ-034 Simultaneous read_i=1 and write_i=1 in IDLE -> WRITE entered; read_o stays 0 for the whole transaction.
REQ-035 rst=1 after beat 2 of a read -> next cycle read_o=0, resp_o=0, line_o=0. A fresh read afterwards completes normally with correct beat placement.
REQ-036 Requests held high through DONE -> exactly one resp_o pulse per completed line. Spurious resp_i in IDLE -> no state change. Back-to-back read then write both complete.
